jtpopeye_rom_arb: RTL and testbench
===================================

# jtpopeye_rom_arb

ROM port arbiter sitting between the download path (prog_* bus from the ROM/PROM write-enable stage) and the single 16-bit SDRAM controller port. During download it serialises byte writes with their active-low lane mask into the memory; after download it shares the port between two read requesters (main CPU and OBJ fetch) with round-robin fairness. It also emits a one-cycle `dwnld_done` once the last download write has actually been issued.

## Interface
- AW, 22, memory word address width
- DW, 16, memory data width

- clk_rom  in  1  ROM clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- downloading  in  1  download in progress; reads are not granted while high
- prog_we  in  1  one-cycle write strobe
- prog_addr  in  AW  word address
- prog_data  in  8  byte, replicated onto both lanes
- prog_mask  in  2  lane mask, active low
- main_req  in  1  level read request; addr stable while high
- main_addr  in  AW  read address
- main_dout  out  DW  read data, valid from main_ok onward
- main_ok  out  1  one-cycle completion pulse
- obj_req, obj_addr, obj_dout, obj_ok  same as main_*
- mem_addr  out  AW  memory address
- mem_din  out  DW  write data {prog_data, prog_data}
- mem_mask  out  2  active-low lane mask; 2'b11 on reads
- mem_we  out  1  one-cycle write command
- mem_rd  out  1  one-cycle read command
- mem_busy  in  1  controller cannot accept a command this cycle
- mem_rdy  in  1  one-cycle read-data-valid pulse
- mem_dout  in  DW  read data, valid with mem_rdy
- dwnld_done  out  1  one-cycle pulse at end of download
- wr_ovf  out  1  sticky: prog_we arrived while holding register full

## Operation
- Write holding register (1 entry): prog_we loads addr/data/mask and sets `wpend`.
  - If `wpend` is already set and is not being issued in the same cycle, the new write is dropped and wr_ovf sets. wr_ovf clears only on reset.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT.
- IDLE priority, highest first:
  1. `wpend` -> WR.
  2. If !downloading, a read request -> RD_ISSUE. The owner is chosen round-robin (`last` bit), and the non-last requester wins ties. `last` resets to obj, so main wins the first tie.
  3. Otherwise stay in IDLE.
- WR: drive mem_we=1 for exactly the first cycle with !mem_busy, then clear `wpend` -> IDLE. A prog_we arriving in that same cycle is accepted (no overflow).
- RD_ISSUE: drive mem_rd=1 in the first cycle with !mem_busy, using the owner's address and mem_mask=2'b11, then -> RD_WAIT.
- RD_WAIT: on mem_rdy, latch mem_dout into the owner's dout, pulse the owner's ok, update `last`, then -> IDLE.
  - An in-flight read always completes, even if downloading rises or `wpend` sets.
- Request rule: a req still high in the cycle after its ok pulse counts as a new request. The requester's dout holds its value until the next completion for that requester.
- dwnld_done pulses once after the falling edge of downloading, at the first cycle with !wpend and state != WR. If a write is pending at the falling edge, the pulse comes one cycle after that write is issued.
- Reset values: all outputs 0 except mem_mask=2'b11; mem_addr=0, mem_din=0, both dout=0. Internally: FSM=IDLE, `wpend`=0, `last`=obj.
- Reset asserted mid-operation aborts everything immediately. No ok pulse is produced for the aborted read; its late mem_rdy is ignored because the FSM is not in RD_WAIT.

## Timing
- Write: prog_we in cycle N -> `wpend` at N+1 -> mem_we at N+1 if the FSM is idle and !mem_busy. Minimum latency 1 cycle.
- Read: req seen in IDLE at N -> RD_ISSUE at N+1 -> mem_rd at N+1 (if !mem_busy) -> ok one cycle after mem_rdy.
- mem_we and mem_rd are never high together; each is high for exactly one cycle per command.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package (jtpopeye_pkg): state encoding localparams (IDLE/WR/RD_ISSUE/RD_WAIT), OWN_MAIN/OWN_OBJ constants.
- One natural sub-module: `jtpopeye_rr2`, a two-requester round-robin picker with a `last` register and an update strobe, reused for other shared ports.

## Test plan
- Download burst: 4 prog_we spaced 2 cycles apart, mem_busy=0 -> 4 mem_we pulses with correct addr, mem_din=16'hXYXY, mask passed through; wr_ovf=0.
- Overflow: mem_busy=1, two prog_we in consecutive cycles -> first write retained and issued after busy drops; second dropped; wr_ovf=1 until reset.
- Round-robin: main_req and obj_req held high, mem_rdy 3 cycles after each mem_rd -> grant order main, obj, main, obj; each ok is a single-cycle pulse with the matching data.
- Read blocked during download: downloading=1, main_req=1 -> no mem_rd. downloading falls with a write pending -> the write issues, dwnld_done pulses one cycle later, then mem_rd for main.
- In-flight read vs write: read in RD_WAIT when prog_we arrives -> read completes (main_ok) before mem_we.
- Reset mid-read: rst_n low in RD_WAIT, release, late mem_rdy -> no ok pulse, all outputs at reset values, FSM in IDLE.

Source files
------------

// File: rtl/jtpopeye_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtpopeye_pkg
//  Description : Shared definitions for the Popeye ROM port arbitration.
//                Arbiter state encoding, requester identifiers, the lane
//                mask used for reads and the two-way round-robin pick rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtpopeye_pkg;

    // Arbiter FSM encoding
    localparam int unsigned ST_W        = 2;
    localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [ST_W-1:0] ST_WR       = 2'd1;
    localparam logic [ST_W-1:0] ST_RD_ISSUE = 2'd2;
    localparam logic [ST_W-1:0] ST_RD_WAIT  = 2'd3;

    // Requester identifiers (request vector bit positions match these values)
    localparam logic OWN_MAIN = 1'b0;
    localparam logic OWN_OBJ  = 1'b1;

    // Active-low lane mask with both lanes disabled: used for every read
    localparam logic [1:0] MASK_RD = 2'b11;

    // Two-way round-robin: on a tie the requester that was NOT served last
    // wins; a lone requester always wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic pick;
        pick = OWN_MAIN;
        if (req == 2'b11) begin
            pick = ~last;
        end else if (req[1]) begin
            pick = OWN_OBJ;
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtpopeye_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : jtpopeye_rr2
//  Description : Two-requester round-robin picker. Holds the identity of the
//                requester served last and offers the other one on a tie.
//                The history only moves when i_upd strobes, so a grant that
//                never completes does not disturb fairness.
//  Ports       : clk, rst_n      clock / async active-low reset
//                i_req[1:0]      request vector (bit 0 main, bit 1 obj)
//                i_upd           completion strobe
//                i_upd_id        requester that just completed
//                o_pick          requester to grant (valid when o_any)
//                o_any           at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module jtpopeye_rr2
    import jtpopeye_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_id,
    output logic       o_pick,
    output logic       o_any
);

    logic r_last;

    always_comb begin
        o_any  = |i_req;
        o_pick = rr_pick(i_req, r_last);
    end

    // Starts on obj so that main wins the very first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= OWN_OBJ;
        end else if (i_upd) begin
            r_last <= i_upd_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtpopeye_rom_arb.sv
`default_nettype none
// ============================================================================
//  Module      : jtpopeye_rom_arb
//  Description : Arbiter for the single 16-bit SDRAM controller port.
//                While downloading, byte writes from the prog_* bus go through
//                a one-entry holding register and are issued with their
//                active-low lane mask. Afterwards the port is shared between
//                the main CPU and the OBJ fetcher with round-robin fairness.
//                dwnld_done pulses once the final download write is issued.
//  Ports       : clk_rom, rst_n               clock / async active-low reset
//                downloading                  download in progress
//                prog_we/addr/data/mask       download byte write
//                main_req/addr/dout/ok        main CPU read port
//                obj_req/addr/dout/ok         OBJ fetch read port
//                mem_addr/din/mask/we/rd      command to SDRAM controller
//                mem_busy/rdy/dout            controller status and read data
//                dwnld_done                   end-of-download pulse
//                wr_ovf                       sticky write overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module jtpopeye_rom_arb
    import jtpopeye_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 16
)(
    input  logic          clk_rom,
    input  logic          rst_n,
    input  logic          downloading,
    // download path
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [1:0]    prog_mask,
    // main CPU read port
    input  logic          main_req,
    input  logic [AW-1:0] main_addr,
    output logic [DW-1:0] main_dout,
    output logic          main_ok,
    // OBJ fetch read port
    input  logic          obj_req,
    input  logic [AW-1:0] obj_addr,
    output logic [DW-1:0] obj_dout,
    output logic          obj_ok,
    // SDRAM controller port
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic [1:0]    mem_mask,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic          mem_busy,
    input  logic          mem_rdy,
    input  logic [DW-1:0] mem_dout,
    // status
    output logic          dwnld_done,
    output logic          wr_ovf
);

    logic [ST_W-1:0] r_state;
    logic            r_owner;

    // write holding register
    logic            r_wpend;
    logic [AW-1:0]   r_waddr;
    logic [7:0]      r_wdata;
    logic [1:0]      r_wmask;

    // end-of-download tracking
    logic            r_dl;
    logic            r_done_arm;

    logic            w_wr_issue;
    logic            w_wr_accept;
    logic            w_rd_done;
    logic            w_arm;
    logic            w_pick;
    logic            w_any;

    // The held write leaves the register this cycle, so a new prog_we can
    // take its place without overflowing.
    assign w_wr_issue  = (r_state == ST_WR) && !mem_busy;
    assign w_wr_accept = prog_we && (!r_wpend || w_wr_issue);
    assign w_rd_done   = (r_state == ST_RD_WAIT) && mem_rdy;
    // Armed from the falling edge of downloading until the pulse is given;
    // a new download start cancels it.
    assign w_arm       = (r_done_arm || r_dl) && !downloading;

    jtpopeye_rr2 u_rr (
        .clk      (clk_rom),
        .rst_n    (rst_n),
        .i_req    ({obj_req, main_req}),
        .i_upd    (w_rd_done),
        .i_upd_id (r_owner),
        .o_pick   (w_pick),
        .o_any    (w_any)
    );

    // ------------------------------------------------------------------
    // Write holding register and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_wpend <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wmask <= MASK_RD;
            wr_ovf  <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wpend <= 1'b1;
                r_waddr <= prog_addr;
                r_wdata <= prog_data;
                r_wmask <= prog_mask;
            end else if (w_wr_issue) begin
                r_wpend <= 1'b0;
            end
            if (prog_we && !w_wr_accept) begin
                wr_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM with registered memory-side and requester-side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_MAIN;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_mask  <= MASK_RD;
            mem_we    <= 1'b0;
            mem_rd    <= 1'b0;
            main_dout <= '0;
            main_ok   <= 1'b0;
            obj_dout  <= '0;
            obj_ok    <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            mem_rd  <= 1'b0;
            main_ok <= 1'b0;
            obj_ok  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // An incoming prog_we is treated as pending already, so
                    // the write state is entered together with r_wpend.
                    if (r_wpend || prog_we) begin
                        r_state <= ST_WR;
                    end else if (!downloading && w_any) begin
                        r_owner <= w_pick;
                        r_state <= ST_RD_ISSUE;
                    end
                end
                ST_WR: begin
                    if (!mem_busy) begin
                        mem_we   <= 1'b1;
                        mem_addr <= r_waddr;
                        mem_din  <= DW'({r_wdata, r_wdata});
                        mem_mask <= r_wmask;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RD_ISSUE: begin
                    if (!mem_busy) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= (r_owner == OWN_OBJ) ? obj_addr : main_addr;
                        mem_mask <= MASK_RD;
                        r_state  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // Nothing preempts an in-flight read
                    if (mem_rdy) begin
                        if (r_owner == OWN_OBJ) begin
                            obj_dout <= mem_dout;
                            obj_ok   <= 1'b1;
                        end else begin
                            main_dout <= mem_dout;
                            main_ok   <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // End-of-download pulse: waits for the holding register to drain and
    // for the last write to leave the WR state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_dl       <= 1'b0;
            r_done_arm <= 1'b0;
            dwnld_done <= 1'b0;
        end else begin
            r_dl       <= downloading;
            dwnld_done <= 1'b0;
            if (w_arm && !r_wpend && (r_state != ST_WR)) begin
                dwnld_done <= 1'b1;
                r_done_arm <= 1'b0;
            end else begin
                r_done_arm <= w_arm;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtpopeye_rom_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtpopeye_rom_arb
//  Description : Directed self-checking bench for jtpopeye_rom_arb. Inputs
//                are driven and outputs sampled on the falling clock edge;
//                a small memory model answers each read 3 cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtpopeye_rom_arb;

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int RD_LAT = 3;

    localparam logic [AW-1:0] MA  = 22'h012345;
    localparam logic [AW-1:0] OA  = 22'h2ABCDE;
    localparam logic [AW-1:0] MA2 = 22'h00F00D;
    localparam logic [AW-1:0] MA3 = 22'h133337;

    logic          clk;
    logic          rst_n;
    logic          downloading;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [1:0]    prog_mask;
    logic          main_req;
    logic [AW-1:0] main_addr;
    logic [DW-1:0] main_dout;
    logic          main_ok;
    logic          obj_req;
    logic [AW-1:0] obj_addr;
    logic [DW-1:0] obj_dout;
    logic          obj_ok;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [1:0]    mem_mask;
    logic          mem_we;
    logic          mem_rd;
    logic          mem_busy;
    logic          mem_rdy;
    logic [DW-1:0] mem_dout;
    logic          dwnld_done;
    logic          wr_ovf;

    int n_vec;
    int n_err;
    int rd_cnt;
    logic [DW-1:0] rd_data;

    jtpopeye_rom_arb #(.AW(AW), .DW(DW)) dut (
        .clk_rom     (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .main_req    (main_req),
        .main_addr   (main_addr),
        .main_dout   (main_dout),
        .main_ok     (main_ok),
        .obj_req     (obj_req),
        .obj_addr    (obj_addr),
        .obj_dout    (obj_dout),
        .obj_ok      (obj_ok),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_mask    (mem_mask),
        .mem_we      (mem_we),
        .mem_rd      (mem_rd),
        .mem_busy    (mem_busy),
        .mem_rdy     (mem_rdy),
        .mem_dout    (mem_dout),
        .dwnld_done  (dwnld_done),
        .wr_ovf      (wr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data returned by the memory model for a given word address
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    // Memory model: answers each mem_rd with a one-cycle mem_rdy RD_LAT
    // cycles later. It keeps counting across a DUT reset on purpose.
    always @(negedge clk) begin
        mem_rdy = 1'b0;
        if (rd_cnt != 0) begin
            rd_cnt = rd_cnt - 1;
            if (rd_cnt == 0) begin
                mem_rdy  = 1'b1;
                mem_dout = rd_data;
            end
        end
        if (mem_rd === 1'b1) begin
            rd_cnt  = RD_LAT;
            rd_data = mem_word(mem_addr);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if (mem_mask !== 2'b11) begin
            n_err++;
            $display("FAIL reset_mask: got %b expected 11", mem_mask);
        end
        n_vec++;
        if ({mem_we, mem_rd, main_ok, obj_ok, dwnld_done, wr_ovf} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {mem_we, mem_rd, main_ok, obj_ok, dwnld_done, wr_ovf});
        end
        n_vec++;
        if ({mem_addr, mem_din, main_dout, obj_dout} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr %h din %h mdout %h odout %h expected all 0",
                     mem_addr, mem_din, main_dout, obj_dout);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_download_burst();
        logic [AW-1:0] addrs [4];
        logic [7:0]    datas [4];
        logic [1:0]    masks [4];
        addrs = '{22'h000010, 22'h000011, 22'h1FFFFF, 22'h3FFFFF};
        datas = '{8'h12, 8'hA5, 8'h00, 8'hFF};
        masks = '{2'b10, 2'b01, 2'b00, 2'b11};
        downloading = 1'b1;
        mem_busy    = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            prog_we   = 1'b1;
            prog_addr = addrs[k];
            prog_data = datas[k];
            prog_mask = masks[k];
            tick();
            prog_we = 1'b0;
            n_vec++;
            if (mem_we !== 1'b0) begin
                n_err++;
                $display("FAIL burst_we_early[%0d]: got %b expected 0", k, mem_we);
            end
            tick();
            n_vec++;
            if (mem_we !== 1'b1 || mem_addr !== addrs[k] ||
                mem_din !== {datas[k], datas[k]} || mem_mask !== masks[k]) begin
                n_err++;
                $display("FAIL burst_write[%0d]: got we %b addr %h din %h mask %b expected we 1 addr %h din %h mask %b",
                         k, mem_we, mem_addr, mem_din, mem_mask,
                         addrs[k], {datas[k], datas[k]}, masks[k]);
            end
        end
        tick();
        n_vec++;
        if (mem_we !== 1'b0 || wr_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL burst_tail: got we %b ovf %b expected 0 0", mem_we, wr_ovf);
        end
        downloading = 1'b0;
        tick();
        n_vec++;
        if (dwnld_done !== 1'b1) begin
            n_err++;
            $display("FAIL burst_done: got %b expected 1", dwnld_done);
        end
        tick();
        n_vec++;
        if (dwnld_done !== 1'b0) begin
            n_err++;
            $display("FAIL burst_done_width: got %b expected 0", dwnld_done);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_overflow();
        int we_cnt;
        downloading = 1'b1;
        mem_busy    = 1'b1;
        tick();
        prog_we = 1'b1; prog_addr = 22'h0000AA; prog_data = 8'h3C; prog_mask = 2'b01;
        tick();
        prog_we = 1'b1; prog_addr = 22'h0000BB; prog_data = 8'hC3; prog_mask = 2'b10;
        tick();
        prog_we = 1'b0;
        n_vec++;
        if (wr_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: got %b expected 1", wr_ovf);
        end
        we_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_we === 1'b1) we_cnt++;
        end
        n_vec++;
        if (we_cnt != 0) begin
            n_err++;
            $display("FAIL ovf_busy_we: got %0d pulses expected 0", we_cnt);
        end
        mem_busy = 1'b0;
        tick();
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 22'h0000AA || mem_din !== 16'h3C3C || mem_mask !== 2'b01) begin
            n_err++;
            $display("FAIL ovf_first_write: got we %b addr %h din %h mask %b expected we 1 addr 0000aa din 3c3c mask 01",
                     mem_we, mem_addr, mem_din, mem_mask);
        end
        we_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_we === 1'b1) we_cnt++;
        end
        n_vec++;
        if (we_cnt != 0 || wr_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_dropped: got %0d extra writes ovf %b expected 0 writes ovf 1", we_cnt, wr_ovf);
        end
        downloading = 1'b0;
        tick();
        n_vec++;
        if (dwnld_done !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_done: got %b expected 1", dwnld_done);
        end
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (wr_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b expected 0", wr_ovf);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        logic [1:0] exp_ok [4];
        logic [1:0] got;
        logic [DW-1:0] exp_d;
        bit found;
        exp_ok = '{2'b10, 2'b01, 2'b10, 2'b01};   // {main_ok, obj_ok}
        downloading = 1'b0;
        main_addr = MA;
        obj_addr  = OA;
        main_req  = 1'b1;
        obj_req   = 1'b1;
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                tick();
                if (main_ok === 1'b1 || obj_ok === 1'b1) found = 1'b1;
            end
            if (g == 3) begin
                main_req = 1'b0;
                obj_req  = 1'b0;
            end
            got = {main_ok, obj_ok};
            n_vec++;
            if (!found || got !== exp_ok[g]) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got ok %b expected %b", g, got, exp_ok[g]);
            end
            exp_d = exp_ok[g][1] ? mem_word(MA) : mem_word(OA);
            n_vec++;
            if ((exp_ok[g][1] ? main_dout : obj_dout) !== exp_d) begin
                n_err++;
                $display("FAIL rr_data[%0d]: got %h expected %h", g,
                         exp_ok[g][1] ? main_dout : obj_dout, exp_d);
            end
            tick();
            n_vec++;
            if (main_ok !== 1'b0 || obj_ok !== 1'b0) begin
                n_err++;
                $display("FAIL rr_ok_width[%0d]: got %b expected 00", g, {main_ok, obj_ok});
            end
        end
        for (int i = 0; i < 8; i++) tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_blocked_download();
        int rd_seen;
        bit found;
        downloading = 1'b1;
        main_addr   = MA;
        main_req    = 1'b1;
        rd_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_rd === 1'b1) rd_seen++;
        end
        mem_busy  = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 22'h055555;
        prog_data = 8'h69;
        prog_mask = 2'b00;
        tick();
        prog_we = 1'b0;
        if (mem_rd === 1'b1) rd_seen++;
        tick();
        if (mem_rd === 1'b1) rd_seen++;
        n_vec++;
        if (rd_seen != 0) begin
            n_err++;
            $display("FAIL blk_no_read: got %0d reads expected 0", rd_seen);
        end
        downloading = 1'b0;
        mem_busy    = 1'b0;
        tick();
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 22'h055555 || mem_din !== 16'h6969 || dwnld_done !== 1'b0) begin
            n_err++;
            $display("FAIL blk_write: got we %b addr %h din %h done %b expected 1 055555 6969 0",
                     mem_we, mem_addr, mem_din, dwnld_done);
        end
        tick();
        n_vec++;
        if (dwnld_done !== 1'b1 || mem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL blk_done: got done %b rd %b expected 1 0", dwnld_done, mem_rd);
        end
        tick();
        n_vec++;
        if (mem_rd !== 1'b1 || mem_addr !== MA || mem_mask !== 2'b11 || dwnld_done !== 1'b0) begin
            n_err++;
            $display("FAIL blk_read: got rd %b addr %h mask %b done %b expected 1 %h 11 0",
                     mem_rd, mem_addr, mem_mask, dwnld_done, MA);
        end
        found = 1'b0;
        for (int t = 0; t < 12 && !found; t++) begin
            tick();
            if (main_ok === 1'b1) found = 1'b1;
        end
        main_req = 1'b0;
        n_vec++;
        if (!found || main_dout !== mem_word(MA)) begin
            n_err++;
            $display("FAIL blk_main_ok: got seen %b data %h expected 1 %h", found, main_dout, mem_word(MA));
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_inflight_read();
        int  t_ok;
        int  t_we;
        bit  found;
        logic [AW-1:0] we_addr;
        downloading = 1'b0;
        main_addr   = MA2;
        main_req    = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            tick();
            if (mem_rd === 1'b1) found = 1'b1;
        end
        // read now in flight: start a new download write on top of it
        downloading = 1'b1;
        prog_we     = 1'b1;
        prog_addr   = 22'h0ABCDE;
        prog_data   = 8'h5E;
        prog_mask   = 2'b10;
        tick();
        prog_we = 1'b0;
        t_ok = -1;
        t_we = -1;
        we_addr = '0;
        for (int t = 1; t < 20; t++) begin
            if (main_ok === 1'b1 && t_ok < 0) begin
                t_ok = t;
                main_req = 1'b0;
            end
            if (mem_we === 1'b1 && t_we < 0) begin
                t_we = t;
                we_addr = mem_addr;
            end
            tick();
        end
        n_vec++;
        if (!found || t_ok < 0 || t_we <= t_ok) begin
            n_err++;
            $display("FAIL inflight_order: got ok at %0d we at %0d expected ok before we", t_ok, t_we);
        end
        n_vec++;
        if (main_dout !== mem_word(MA2) || we_addr !== 22'h0ABCDE) begin
            n_err++;
            $display("FAIL inflight_data: got dout %h we_addr %h expected %h 0abcde",
                     main_dout, we_addr, mem_word(MA2));
        end
        downloading = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 6 && !found; t++) begin
            tick();
            if (dwnld_done === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL inflight_done: got no pulse expected dwnld_done");
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_read();
        int  ok_cnt;
        bit  found;
        main_addr = MA3;
        main_req  = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            tick();
            if (mem_rd === 1'b1) found = 1'b1;
        end
        tick();            // FSM waiting for read data
        rst_n    = 1'b0;
        main_req = 1'b0;
        tick();
        n_vec++;
        if (!found || mem_mask !== 2'b11 || mem_addr !== '0 || main_dout !== '0 ||
            {mem_we, mem_rd, main_ok, obj_ok, dwnld_done, wr_ovf} !== 6'b0) begin
            n_err++;
            $display("FAIL midrst_outputs: got rd_seen %b mask %b addr %h dout %h flags %b expected 1 11 0 0 0",
                     found, mem_mask, mem_addr, main_dout,
                     {mem_we, mem_rd, main_ok, obj_ok, dwnld_done, wr_ovf});
        end
        rst_n = 1'b1;
        ok_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (main_ok === 1'b1 || obj_ok === 1'b1 || mem_rd === 1'b1) ok_cnt++;
        end
        n_vec++;
        if (ok_cnt != 0 || main_dout !== '0) begin
            n_err++;
            $display("FAIL midrst_late_rdy: got %0d ok/rd events dout %h expected 0 0", ok_cnt, main_dout);
        end
        // idle FSM and fresh round-robin history: main wins the first tie
        main_addr = MA;
        obj_addr  = OA;
        main_req  = 1'b1;
        obj_req   = 1'b1;
        tick();
        tick();
        n_vec++;
        if (mem_rd !== 1'b1 || mem_addr !== MA) begin
            n_err++;
            $display("FAIL midrst_first_grant: got rd %b addr %h expected 1 %h", mem_rd, mem_addr, MA);
        end
        found = 1'b0;
        for (int t = 0; t < 12 && !found; t++) begin
            tick();
            if (main_ok === 1'b1 || obj_ok === 1'b1) found = 1'b1;
        end
        main_req = 1'b0;
        obj_req  = 1'b0;
        n_vec++;
        if (!found || main_ok !== 1'b1 || main_dout !== mem_word(MA)) begin
            n_err++;
            $display("FAIL midrst_main_ok: got ok %b data %h expected 1 %h", main_ok, main_dout, mem_word(MA));
        end
        for (int i = 0; i < 8; i++) tick();
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_vec       = 0;
        n_err       = 0;
        rd_cnt      = 0;
        rd_data     = '0;
        rst_n       = 1'b0;
        downloading = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_mask   = 2'b11;
        main_req    = 1'b0;
        main_addr   = '0;
        obj_req     = 1'b0;
        obj_addr    = '0;
        mem_busy    = 1'b0;
        mem_rdy     = 1'b0;
        mem_dout    = '0;

        test_reset();
        test_download_burst();
        test_overflow();
        test_round_robin();
        test_blocked_download();
        test_inflight_read();
        test_reset_mid_read();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
